sky130_sram_1rw_param: RTL and testbench

Parametrised single-port (1RW) synchronous SRAM with per-lane write mask. It is the generalised successor of the fixed 16x32 tiny SRAM macro model and is fully synthesizable with a clean reset. It adds configurable width, depth and mask granularity, 1- or 2-cycle read latency, a selectable write-port read mode, and an optional clear-on-reset sequencer with a ready flag. It is used as a drop-in memory for testchip datapaths and as a golden model for the hardened macros.

---
 rtl/sky130_sram_1rw_param.sv | 113 +++++++++++
 tb/tb_sky130_sram_1rw_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sky130_sram_1rw_param.sv
// sky130_sram_1rw_param: parametrised 1RW synchronous SRAM with lane write mask, clear-on-reset and 1/2-cycle reads
module sky130_sram_1rw_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int WMASK_WIDTH    = 8,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NUM_WMASKS    = DATA_WIDTH / WMASK_WIDTH,
    localparam int DEPTH         = 1 << ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout_valid0,
    output logic                  ready0
);
    typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clear_we, acc, out_en, stage_v;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word, merged, out_word, stage_d;

    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
        $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $error("READ_LATENCY must be 1 or 2");
    end
    if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_bad_mode
        $error("WRITE_MODE must be 0, 1 or 2");
    end

    assign ready0   = state == S_READY;
    assign acc      = !rst0 && ready0 && !csb0;
    assign rd_word  = mem[addr0];
    assign out_en   = acc && (web0 || WRITE_MODE != 0);
    assign out_word = (!web0 && WRITE_MODE == 1) ? merged : rd_word;

    // Lane merge of incoming data over the currently stored word
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NUM_WMASKS; i++)
            if (wmask0[i]) merged[i*WMASK_WIDTH +: WMASK_WIDTH] = din0[i*WMASK_WIDTH +: WMASK_WIDTH];
    end

    // State register and clear pointer; reset restarts the clear from word 0
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state    <= S_RESET;
            clr_addr <= '0;
        end else begin
            state    <= state_n;
            clr_addr <= clear_we ? clr_addr + 1'b1 : clr_addr;
        end
    end

    // Every non-ready cycle clears one word; the last word's clear makes the array ready
    always_comb begin
        state_n  = state;
        clear_we = 1'b0;
        if (state != S_READY) begin
            clear_we = CLEAR_ON_RESET != 0;
            state_n  = (CLEAR_ON_RESET == 0 || &clr_addr) ? S_READY : S_CLEAR;
        end
    end

    // Array write port: clear sequencer and user writes never overlap because writes need ready0
    always_ff @(posedge clk0) begin
        if (!rst0 && clear_we)
            mem[clr_addr] <= '0;
        else if (acc && !web0)
            mem[addr0] <= merged;
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  pipe_v;
        logic [DATA_WIDTH-1:0] pipe_d;
        // Extra read stage; flushed by reset so in-flight reads never pulse
        always_ff @(posedge clk0) begin
            if (rst0) begin
                pipe_v <= 1'b0;
                pipe_d <= '0;
            end else begin
                pipe_v <= out_en;
                pipe_d <= out_en ? out_word : pipe_d;
            end
        end
        assign stage_v = pipe_v;
        assign stage_d = pipe_d;
    end else begin : g_lat1
        assign stage_v = out_en;
        assign stage_d = out_word;
    end

    // Output register holds its value between updates
    always_ff @(posedge clk0) begin
        if (rst0) begin
            dout0       <= '0;
            dout_valid0 <= 1'b0;
        end else begin
            dout_valid0 <= stage_v;
            dout0       <= stage_v ? stage_d : dout0;
        end
    end
endmodule

// File: tb/tb_sky130_sram_1rw_param.sv
// tb_sky130_sram_1rw_param: four 32-bit latency/write-mode variants against a scheduled reference model, plus a 64-bit variant
module tb_sky130_sram_1rw_param;
    localparam int LAT[4]  = '{1, 2, 1, 2};
    localparam int MODE[4] = '{0, 1, 2, 0};

    logic        clk = 1'b0, rst = 1'b1, csb = 1'b1, web = 1'b1;
    logic [3:0]  wmask = '0, addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout_a [4];
    logic        valid_a [4], ready_a [4];

    logic        w_csb = 1'b1, w_web = 1'b1;
    logic [3:0]  w_wmask = '0;
    logic [5:0]  w_addr = '0;
    logic [63:0] w_din = '0, w_dout;
    logic        w_valid, w_ready;

    int n_chk = 0, n_fail = 0, n_edge = 0;

    logic [31:0] m_mem [16];
    int          m_cnt = 0;
    logic [31:0] exp_d [4];
    logic        exp_v [4];
    logic        slot_v [4][4];
    logic [31:0] slot_d [4][4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sky130_sram_1rw_param #(.READ_LATENCY((g % 2) + 1), .WRITE_MODE(g == 1 ? 1 : g == 2 ? 2 : 0)) u_dut (
            .clk0(clk), .rst0(rst), .csb0(csb), .web0(web), .wmask0(wmask), .addr0(addr), .din0(din),
            .dout0(dout_a[g]), .dout_valid0(valid_a[g]), .ready0(ready_a[g])
        );
    end

    sky130_sram_1rw_param #(.DATA_WIDTH(64), .WMASK_WIDTH(16), .ADDR_WIDTH(6), .WRITE_MODE(1)) u_wide (
        .clk0(clk), .rst0(rst), .csb0(w_csb), .web0(w_web), .wmask0(w_wmask), .addr0(w_addr), .din0(w_din),
        .dout0(w_dout), .dout_valid0(w_valid), .ready0(w_ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        logic        acc;
        logic [31:0] old, mrg;
        acc = !rst && m_cnt >= 16 && !csb;
        old = m_mem[addr];
        for (int i = 0; i < 4; i++) mrg[i*8 +: 8] = wmask[i] ? din[i*8 +: 8] : old[i*8 +: 8];
        for (int d = 0; d < 4; d++) begin
            if (rst) begin
                exp_d[d] = '0;
                exp_v[d] = 1'b0;
                for (int j = 0; j < 4; j++) slot_v[d][j] = 1'b0;
            end else begin
                if (acc && (web || MODE[d] != 0)) begin
                    int s;
                    s = (n_edge + LAT[d] - 1) % 4;
                    slot_v[d][s] = 1'b1;
                    slot_d[d][s] = (web || MODE[d] == 2) ? old : mrg;
                end
                exp_v[d] = slot_v[d][n_edge % 4];
                if (exp_v[d]) exp_d[d] = slot_d[d][n_edge % 4];
                slot_v[d][n_edge % 4] = 1'b0;
            end
        end
        if (rst) m_cnt = 0;
        else if (m_cnt < 16) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
        end else if (acc && !web) m_mem[addr] = mrg;
        n_edge++;
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("ready d%0d e%0d", d, n_edge), 64'(ready_a[d]), 64'(m_cnt >= 16));
            chk($sformatf("valid d%0d e%0d", d, n_edge), 64'(valid_a[d]), 64'(exp_v[d]));
            chk($sformatf("dout d%0d e%0d", d, n_edge), 64'(dout_a[d]), 64'(exp_d[d]));
        end
    endtask

    typedef struct {
        logic        csb, web;
        logic [3:0]  wm, a;
        logic [31:0] din, e0_d;
        logic        e0_v;
        logic [31:0] e2_d;
        logic        e2_v;
    } vec_t;
    vec_t tbl [9];

    initial begin
        int r32, rw, pulses;
        tbl[0] = '{1'b0, 1'b0, 4'hF, 4'd5, 32'hAABBCCDD, 32'h0, 1'b0, 32'h0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 4'h5, 4'd5, 32'h11223344, 32'h0, 1'b0, 32'hAABBCCDD, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 4'hF, 4'd7, 32'h12345678, 32'hAA22CC44, 1'b0, 32'h0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 4'h3, 4'd7, 32'hFFFFFFFF, 32'hAA22CC44, 1'b0, 32'h12345678, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 4'h0, 4'd7, 32'h0, 32'h1234FFFF, 1'b1, 32'h1234FFFF, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 4'h0, 4'd7, 32'h0, 32'h1234FFFF, 1'b0, 32'h1234FFFF, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 4'h0, 4'd7, 32'h0, 32'h1234FFFF, 1'b0, 32'h1234FFFF, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 4'h0, 4'd7, 32'h0, 32'h1234FFFF, 1'b1, 32'h1234FFFF, 1'b1};

        // Clear and ready timing for both widths
        tick();
        tick();
        rst = 1'b0;
        r32 = 0;
        rw = 0;
        for (int k = 1; k <= 100 && rw == 0; k++) begin
            tick();
            if (ready_a[0] && r32 == 0) r32 = k;
            if (w_ready && rw == 0) rw = k;
        end
        chk("ready32 edges", 64'(r32), 64'd16);
        chk("ready64 edges", 64'(rw), 64'd64);

        // 64-bit variant: full write/read at top address, cleared word, lane merge
        w_csb = 1'b0; w_web = 1'b0; w_addr = 6'd63; w_din = 64'h0123456789ABCDEF; w_wmask = 4'hF;
        tick();
        w_web = 1'b1;
        tick();
        chk("wide rd63", w_dout, 64'h0123456789ABCDEF);
        chk("wide rd63 valid", 64'(w_valid), 64'd1);
        w_addr = 6'd0;
        tick();
        chk("wide rd0", w_dout, 64'h0);
        w_web = 1'b0; w_wmask = 4'b0010; w_din = '1;
        tick();
        w_web = 1'b1;
        tick();
        chk("wide merge", w_dout, 64'h00000000FFFF0000);
        w_csb = 1'b1;

        // Every cleared word reads back zero with one pulse each
        csb = 1'b0; web = 1'b1; pulses = 0;
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            tick();
            if (valid_a[0] && dout_a[0] == 32'h0) pulses++;
        end
        csb = 1'b1;
        tick();
        chk("clear read pulses", 64'(pulses), 64'd16);

        // Masked merge and write-mode table
        for (int i = 0; i < 9; i++) begin
            csb = tbl[i].csb; web = tbl[i].web; wmask = tbl[i].wm; addr = tbl[i].a; din = tbl[i].din;
            tick();
            chk($sformatf("tbl%0d d0 dout", i), 64'(dout_a[0]), 64'(tbl[i].e0_d));
            chk($sformatf("tbl%0d d0 valid", i), 64'(valid_a[0]), 64'(tbl[i].e0_v));
            chk($sformatf("tbl%0d d2 dout", i), 64'(dout_a[2]), 64'(tbl[i].e2_d));
            chk($sformatf("tbl%0d d2 valid", i), 64'(valid_a[2]), 64'(tbl[i].e2_v));
            if (i == 4) begin
                csb = 1'b1;
                tick();
                chk("mode1 writethrough", 64'(dout_a[1]), 64'h1234FFFF);
                chk("mode1 wt valid", 64'(valid_a[1]), 64'd1);
            end
        end

        // Latency 1 vs 2 on back-to-back reads
        csb = 1'b0; web = 1'b0; wmask = 4'hF;
        for (int a = 1; a <= 3; a++) begin
            addr = 4'(a);
            din = 32'(a);
            tick();
        end
        web = 1'b1;
        for (int j = 0; j < 5; j++) begin
            csb = j >= 3;
            addr = 4'(j + 1);
            tick();
            chk($sformatf("lat1 valid j%0d", j), 64'(valid_a[0]), 64'(j < 3));
            if (j < 3) chk($sformatf("lat1 dout j%0d", j), 64'(dout_a[0]), 64'(j + 1));
            chk($sformatf("lat2 valid j%0d", j), 64'(valid_a[3]), 64'(j >= 1 && j <= 3));
            if (j >= 1 && j <= 3) chk($sformatf("lat2 dout j%0d", j), 64'(dout_a[3]), 64'(j));
        end

        // Reset at clear address 9; accesses while not ready are ignored
        csb = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        csb = 1'b0; web = 1'b0; addr = 4'd3; din = 32'hDEADBEEF; wmask = 4'hF;
        r32 = 0;
        for (int k = 1; k <= 40 && r32 == 0; k++) begin
            tick();
            if (ready_a[0]) r32 = k;
        end
        chk("ready after midclear", 64'(r32), 64'd16);
        web = 1'b1;
        tick();
        chk("addr3 ignored", 64'(dout_a[0]), 64'h0);
        chk("addr3 valid", 64'(valid_a[0]), 64'd1);

        // Randomised traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            rst = $urandom_range(0, 99) == 0;
            csb = $urandom_range(0, 3) == 0;
            web = $urandom_range(0, 1) == 1;
            wmask = 4'($urandom);
            addr = 4'($urandom);
            din = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
